alu_pipe_unit: RTL and testbench
================================

Name: alu_pipe_unit

Overview:
- Parametrised integer functional unit; successor to the single-purpose add/sub units behind the reservation stations.
- Accepts one issued operation per cycle (operands, opcode, ROB tag) over a valid/ready handshake.
- Computes the result in a configurable-depth pipeline and presents result+tag for common-data-bus broadcast under a valid/ready grant.
- Supports branch-mispredict flush of all in-flight work.

Parameters:
- WIDTH, 32, operand/result width in bits (>=8).
- TAG_W, 5, ROB index width carried with each operation.
- LATENCY, 2, pipeline stages from accept to result (1..8).

Ports:
- clk  in  1  clock; all state on rising edge.
- RST  in  1  asynchronous, active-high reset.
- in_valid  in  1  issue request from reservation station.
- in_ready  out  1  unit can accept this cycle.
- in_op  in  3  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT (signed), 6 SLTU, 7 SEQ.
- in_a  in  WIDTH  operand 1.
- in_b  in  WIDTH  operand 2.
- in_tag  in  TAG_W  ROB index of the operation.
- flush  in  1  discard all in-flight operations.
- out_valid  out  1  result available for broadcast.
- out_ready  in  1  CDB grant; result consumed when out_valid && out_ready.
- out_result  out  WIDTH  result.
- out_tag  out  TAG_W  ROB index of the result.
- occupancy  out  clog2(LATENCY+1)  number of valid pipeline stages.

Behaviour:
- Stages s[0..LATENCY-1] each hold valid, result, tag; s[LATENCY-1] drives outputs.
- Result is computed combinationally from in_* and captured into s[0] at the accepting edge.
- Arithmetic is modulo 2^WIDTH; no overflow flag.
- SLT, SLTU, SEQ yield 1 or 0, zero-extended to WIDTH.
- Accept occurs when in_valid && in_ready at a rising edge.
- With no backpressure, out_valid first goes high LATENCY-1 edges after the accepting edge (LATENCY=1: the cycle right after accept).
- Advance rule: s[i] moves to s[i+1] when s[i+1] is empty or is itself advancing. The output stage empties on out_valid && out_ready. Bubbles collapse.
- in_ready = !RST && !flush && (s[0] empty || s[0] advancing). This is a combinational path from out_ready.
- Throughput is 1 op/cycle with out_ready held high.
- Backpressure: while out_valid && !out_ready, out_result and out_tag stay stable. Upstream stages fill, then in_ready drops.
- A stage without valid holds result=0 and tag=0, so out_result and out_tag are 0 whenever out_valid=0.
- occupancy equals the count of valid stages after each edge.
- Flush (synchronous): at an edge with flush=1, all stage valids clear and data is zeroed. in_valid in that cycle is not accepted. An out handshake in the flush cycle is discarded: the ROB flushes too.
- From the cycle after a flush the unit is empty and accepting.
- Reset: on RST assertion, immediately (asynchronously) out_valid=0, out_result=0, out_tag=0, occupancy=0, in_ready=0, and all stages are cleared. This applies mid-operation too; no partial result survives.
- First accept is possible in the first cycle after RST deasserts, with in_ready=1.
- Simultaneous out handshake and accept with a full pipeline is allowed; occupancy is unchanged.

Test Plan:
- LATENCY=3, ADD a=5 b=7 tag=3 accepted at edge E, out_ready=1 -> out_valid=1, out_result=12, out_tag=3 after edge E+2 for exactly one cycle.
- SUB a=0 b=1 -> 0xFFFFFFFF. SLT a=0xFFFFFFFF b=1 -> 1. SLTU same operands -> 0. SEQ a=b=9 -> 1. XOR 0xF0F0 ^ 0x0FF0 -> 0xFF00.
- Eight back-to-back ADDs with tags 0..7, out_ready=1 -> eight consecutive out_valid cycles with tags in order, and in_ready never drops.
- out_ready=0 for 5 cycles while issuing continuously -> in_ready=0 once occupancy=LATENCY, output held stable. Release -> no results lost or reordered.
- Two ops in flight, flush pulse -> next cycle occupancy=0 and out_valid=0, no result with those tags ever appears, and a new op is accepted next cycle.
- RST asserted mid-cycle with occupancy=2 -> outputs zero without a clock edge. After release, an ADD 1+1 returns 2 with the correct latency.

Source files
------------

// File: rtl/alu_pipe_unit.sv
// Pipelined integer functional unit: issue handshake in, result+tag out for CDB broadcast.
// Bubbles collapse; a flush or reset empties the pipe, and empty stages always hold zeros.
module alu_pipe_unit #(
  parameter  int WIDTH   = 32,
  parameter  int TAG_W   = 5,
  parameter  int LATENCY = 2,
  localparam int OCC_W   = $clog2(LATENCY + 1)
) (
  input  logic             clk,
  input  logic             RST,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic [OCC_W-1:0] occupancy
);

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_AND  = 3'd2;
  localparam logic [2:0] OP_OR   = 3'd3;
  localparam logic [2:0] OP_XOR  = 3'd4;
  localparam logic [2:0] OP_SLT  = 3'd5;
  localparam logic [2:0] OP_SLTU = 3'd6;
  localparam logic [2:0] OP_SEQ  = 3'd7;

  logic [LATENCY-1:0] vld_q;
  logic [WIDTH-1:0]   res_q [LATENCY];
  logic [TAG_W-1:0]   tag_q [LATENCY];
  logic [LATENCY-1:0] space;
  logic [WIDTH-1:0]   alu_res;
  logic [OCC_W-1:0]   occ_sum;
  logic               accept;

  always_comb begin
    alu_res = '0;
    case (in_op)
      OP_ADD:  alu_res = in_a + in_b;
      OP_SUB:  alu_res = in_a - in_b;
      OP_AND:  alu_res = in_a & in_b;
      OP_OR:   alu_res = in_a | in_b;
      OP_XOR:  alu_res = in_a ^ in_b;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(in_a) < $signed(in_b))};
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (in_a < in_b)};
      OP_SEQ:  alu_res = {{(WIDTH-1){1'b0}}, (in_a == in_b)};
      default: alu_res = '0;
    endcase
  end

  // A stage can take new data if the output drains this cycle or any stage at or
  // downstream of it is empty (the bubble absorbs the shift). Closed form avoids a
  // bit-to-bit combinational chain.
  for (genvar g = 0; g < LATENCY; g++) begin : g_space
    assign space[g] = out_ready || !(&vld_q[LATENCY-1:g]);
  end

  assign in_ready = !RST && !flush && space[0];
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      vld_q <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        res_q[i] <= '0;
        tag_q[i] <= '0;
      end
    end else if (flush) begin
      vld_q <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        res_q[i] <= '0;
        tag_q[i] <= '0;
      end
    end else begin
      if (space[0]) begin
        vld_q[0] <= accept;
        res_q[0] <= accept ? alu_res : '0;
        tag_q[0] <= accept ? in_tag  : '0;
      end
      // Empty stages carry zeros, so a plain copy keeps that invariant.
      for (int i = 1; i < LATENCY; i++) begin
        if (space[i]) begin
          vld_q[i] <= vld_q[i-1];
          res_q[i] <= res_q[i-1];
          tag_q[i] <= tag_q[i-1];
        end
      end
    end
  end

  always_comb begin
    occ_sum = '0;
    for (int i = 0; i < LATENCY; i++) occ_sum = occ_sum + OCC_W'(vld_q[i]);
  end

  assign occupancy  = occ_sum;
  assign out_valid  = vld_q[LATENCY-1];
  assign out_result = res_q[LATENCY-1];
  assign out_tag    = tag_q[LATENCY-1];

endmodule

// File: tb/tb_alu_pipe_unit.sv
// Directed bench for alu_pipe_unit (LATENCY=3): opcode table plus streaming,
// backpressure, flush and asynchronous reset sequences.
module tb_alu_pipe_unit;
  localparam int W = 32;
  localparam int T = 5;
  localparam int L = 3;

  logic         clk = 1'b0;
  logic         RST;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   in_op;
  logic [W-1:0] in_a, in_b;
  logic [T-1:0] in_tag;
  logic         flush;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_result;
  logic [T-1:0] out_tag;
  logic [1:0]   occupancy;

  int n_checks = 0;
  int n_fail   = 0;

  alu_pipe_unit #(.WIDTH(W), .TAG_W(T), .LATENCY(L)) dut (
    .clk(clk), .RST(RST), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_result(out_result), .out_tag(out_tag), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [T-1:0] tag;
    logic [W-1:0] exp;
    string        name;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [T-1:0] tag, input string name);
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_tag = tag;
    @(negedge clk);
    chk({name, " in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic expect_next(input logic [W-1:0] er, input logic [T-1:0] et,
                             input string name, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 12);
    chk({name, " valid"}, 32'(out_valid), 32'd1);
    chk({name, " result"}, out_result, er);
    chk({name, " tag"}, 32'(out_tag), 32'(et));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int k;
    logic rdy;
    logic have_held;
    logic [W-1:0] held_res;
    logic [T-1:0] held_tag;

    vecs[0]  = '{3'd0, 32'd5,        32'd7,        5'd3,  32'd12,       "ADD 5+7"};
    vecs[1]  = '{3'd1, 32'd0,        32'd1,        5'd4,  32'hFFFFFFFF, "SUB 0-1"};
    vecs[2]  = '{3'd5, 32'hFFFFFFFF, 32'd1,        5'd5,  32'd1,        "SLT -1<1"};
    vecs[3]  = '{3'd6, 32'hFFFFFFFF, 32'd1,        5'd6,  32'd0,        "SLTU max<1"};
    vecs[4]  = '{3'd7, 32'd9,        32'd9,        5'd7,  32'd1,        "SEQ 9==9"};
    vecs[5]  = '{3'd4, 32'h0000F0F0, 32'h00000FF0, 5'd8,  32'h0000FF00, "XOR"};
    vecs[6]  = '{3'd2, 32'h0000F0F0, 32'h00000FF0, 5'd9,  32'h000000F0, "AND"};
    vecs[7]  = '{3'd3, 32'h0000F0F0, 32'h00000FF0, 5'd10, 32'h0000FFF0, "OR"};
    vecs[8]  = '{3'd0, 32'hFFFFFFFF, 32'd1,        5'd11, 32'd0,        "ADD wrap"};
    vecs[9]  = '{3'd5, 32'd1,        32'hFFFFFFFF, 5'd12, 32'd0,        "SLT 1<-1"};
    vecs[10] = '{3'd6, 32'd1,        32'hFFFFFFFF, 5'd13, 32'd1,        "SLTU 1<max"};
    vecs[11] = '{3'd7, 32'd9,        32'd8,        5'd31, 32'd0,        "SEQ 9==8"};

    RST = 1'b1; in_valid = 1'b0; in_op = '0; in_a = '0; in_b = '0; in_tag = '0;
    flush = 1'b0; out_ready = 1'b1;
    #12;
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset out_result", out_result, 32'd0);
    chk("reset occupancy", 32'(occupancy), 32'd0);
    chk("reset in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    RST = 1'b0;

    // opcode table, one op at a time, latency and single-cycle output checked
    for (int i = 0; i < 12; i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].tag, vecs[i].name);
      expect_next(vecs[i].exp, vecs[i].tag, vecs[i].name, n);
      chk({vecs[i].name, " latency"}, 32'(n), 32'(L));
      @(negedge clk);
      chk({vecs[i].name, " one cycle"}, 32'(out_valid), 32'd0);
      chk({vecs[i].name, " idle result"}, out_result, 32'd0);
      @(posedge clk); #1;
    end

    // eight back-to-back ADDs at full throughput
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          in_valid = 1'b1; in_op = 3'd0; in_a = 32'(i); in_b = 32'(10 * i); in_tag = 5'(i);
          @(negedge clk);
          chk("b2b in_ready", 32'(in_ready), 32'd1);
          @(posedge clk); #1;
        end
        in_valid = 1'b0;
      end
      begin
        int m;
        for (int j = 0; j < 8; j++) begin
          expect_next(32'(11 * j), 5'(j), "b2b", m);
          if (j > 0) chk("b2b gap", 32'(m), 32'd1);
        end
      end
    join
    @(posedge clk); #1;

    // backpressure: output stalled while issue keeps trying
    out_ready = 1'b0;
    k = 0; have_held = 1'b0; held_res = '0; held_tag = '0;
    in_valid = 1'b1; in_op = 3'd0; in_a = 32'(k); in_b = 32'd100; in_tag = 5'(10 + k);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      rdy = in_ready;
      if (occupancy == 2'd3) chk("bp in_ready at full", 32'(in_ready), 32'd0);
      if (out_valid) begin
        if (have_held) begin
          chk("bp held result", out_result, held_res);
          chk("bp held tag", 32'(out_tag), 32'(held_tag));
        end else begin
          have_held = 1'b1; held_res = out_result; held_tag = out_tag;
        end
      end
      @(posedge clk); #1;
      if (rdy) begin
        k++;
        in_a = 32'(k); in_tag = 5'(10 + k);
      end
    end
    chk("bp accepted", 32'(k), 32'd3);
    chk("bp occupancy", 32'(occupancy), 32'd3);
    chk("bp held seen", 32'(have_held), 32'd1);
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int j = 0; j < 3; j++) expect_next(32'(100 + j), 5'(10 + j), "bp drain", n);
    @(negedge clk);
    chk("bp drained valid", 32'(out_valid), 32'd0);
    chk("bp drained occupancy", 32'(occupancy), 32'd0);
    @(posedge clk); #1;

    // flush with two ops in flight
    in_valid = 1'b1; in_op = 3'd0; in_a = 32'd1; in_b = 32'd1; in_tag = 5'd20;
    @(posedge clk); #1;
    in_tag = 5'd21;
    @(posedge clk); #1;
    chk("flush pre occupancy", 32'(occupancy), 32'd2);
    flush = 1'b1; in_a = 32'd7; in_b = 32'd7; in_tag = 5'd22;
    @(negedge clk);
    chk("flush in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    flush = 1'b0; in_a = 32'd2; in_b = 32'd3; in_tag = 5'd23;
    @(negedge clk);
    chk("flush occupancy", 32'(occupancy), 32'd0);
    chk("flush out_valid", 32'(out_valid), 32'd0);
    chk("flush in_ready after", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    expect_next(32'd5, 5'd23, "post flush", n);
    chk("post flush latency", 32'(n), 32'(L));
    @(posedge clk); #1;

    // asynchronous reset mid-operation
    in_valid = 1'b1; in_op = 3'd0; in_a = 32'd4; in_b = 32'd4; in_tag = 5'd24;
    @(posedge clk); #1;
    in_tag = 5'd25;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("rst pre occupancy", 32'(occupancy), 32'd2);
    #2 RST = 1'b1;
    #1;
    chk("rst async occupancy", 32'(occupancy), 32'd0);
    chk("rst async out_valid", 32'(out_valid), 32'd0);
    chk("rst async out_result", out_result, 32'd0);
    chk("rst async out_tag", 32'(out_tag), 32'd0);
    chk("rst async in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    RST = 1'b0;
    issue(3'd0, 32'd1, 32'd1, 5'd26, "after rst");
    expect_next(32'd2, 5'd26, "after rst", n);
    chk("after rst latency", 32'(n), 32'(L));
    @(negedge clk);
    chk("after rst one cycle", 32'(out_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
